// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit. A start pulse latches both operands.
// WIDTH iterations follow, then one DONE cycle that registers the result and
// the exception flag and pulses data_resultRDY.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;
  logic   start;
  logic   [CW-1:0] cnt;
  logic   op_mul;

  // Multiply: 2*WIDTH signed accumulator; the multiplicand is shifted left
  // each cycle and the multiplier is consumed LSB first.
  logic signed [2*WIDTH-1:0] acc;
  logic signed [2*WIDTH-1:0] mcand;
  logic        [WIDTH-1:0]   mplier;

  // Divide: restoring division on magnitudes; quo starts out holding |A|
  // and fills with quotient bits from the right.
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic             q_neg;
  logic             div_zero;
  logic             div_ovf;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    // MIN maps onto itself, which reads correctly as unsigned 2^(WIDTH-1).
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic fits_signed(input logic [WIDTH:0] top);
    // The product fits in WIDTH signed bits iff its upper WIDTH+1 bits agree.
    return (&top) | (~|top);
  endfunction

  assign start   = ctrl_MULT | ctrl_DIV;
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, dvsr};
  assign rem_ge  = ~rem_sub[WIDTH];

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a start from any state restarts, multiply has priority.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      MUL:     if (cnt == LAST) state_nxt = DONE;
      DIV:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = ctrl_MULT ? MUL : DIV;
  end

  // Operand capture, per-cycle iteration and result write-back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      op_mul         <= 1'b0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      quo            <= '0;
      dvsr           <= '0;
      rem            <= '0;
      q_neg          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        cnt      <= '0;
        op_mul   <= ctrl_MULT;
        acc      <= '0;
        mcand    <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
        mplier   <= data_operandB;
        quo      <= mag(data_operandA);
        dvsr     <= mag(data_operandB);
        rem      <= '0;
        q_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == MIN) && (data_operandB == '1);
      end else begin
        case (state)
          MUL: begin
            // The multiplier's sign bit carries weight -2^(WIDTH-1).
            if (mplier[0]) acc <= (cnt == LAST) ? (acc - mcand) : (acc + mcand);
            mcand  <= mcand <<< 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
          DIV: begin
            rem <= rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], rem_ge};
            cnt <= cnt + 1'b1;
          end
          DONE: begin
            data_resultRDY <= 1'b1;
            if (op_mul) begin
              data_result    <= acc[WIDTH-1:0];
              data_exception <= ~fits_signed(acc[2*WIDTH-1:WIDTH-1]);
            end else if (div_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else if (div_ovf) begin
              data_result    <= MIN;
              data_exception <= 1'b1;
            end else begin
              data_result    <= neg_if(q_neg, quo);
              data_exception <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter at WIDTH=32 and WIDTH=8.
module tb_multdiv_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        m32 = 1'b0, d32 = 1'b0;
  logic [31:0] r32;
  logic        e32, rdy32, busy32;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        m8 = 1'b0, d8 = 1'b0;
  logic [7:0]  r8;
  logic        e8, rdy8, busy8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multdiv_iter #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst_n), .data_operandA(a32), .data_operandB(b32),
    .ctrl_MULT(m32), .ctrl_DIV(d32), .data_result(r32), .data_exception(e32),
    .data_resultRDY(rdy32), .busy(busy32)
  );

  multdiv_iter #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst_n), .data_operandA(a8), .data_operandB(b8),
    .ctrl_MULT(m8), .ctrl_DIV(d8), .data_result(r8), .data_exception(e8),
    .data_resultRDY(rdy8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse, then watch at negedges until RDY (bounded).
  task automatic do_op(input bit w8, input bit m, input bit d,
                       input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic exc,
                       output bit busy_ok, output logic busy_at_rdy, output logic rdy_next);
    @(negedge clk);
    if (w8) begin a8 = a[7:0]; b8 = b[7:0]; m8 = m; d8 = d; end
    else    begin a32 = a;     b32 = b;     m32 = m; d32 = d; end
    @(negedge clk);
    m8 = 1'b0; d8 = 1'b0; m32 = 1'b0; d32 = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    busy_at_rdy = 1'bx;
    for (int k = 0; k <= 60; k++) begin
      if (w8 ? rdy8 : rdy32) begin
        lat = k;
        busy_at_rdy = w8 ? busy8 : busy32;
        break;
      end
      if (!(w8 ? busy8 : busy32)) busy_ok = 1'b0;
      @(negedge clk);
    end
    res = w8 ? {24'h0, r8} : r32;
    exc = w8 ? e8 : e32;
    @(negedge clk);
    rdy_next = w8 ? rdy8 : rdy32;
  endtask

  task automatic check_op(input string tag, input bit w8, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e);
    int lat;
    logic [31:0] res;
    logic exc, bar, rn;
    bit bok;
    do_op(w8, m, d, a, b, lat, res, exc, bok, bar, rn);
    chk({tag, "_latency"}, 32'(lat), w8 ? 32'd9 : 32'd33);
    chk({tag, "_busy_held"}, {31'h0, bok}, 32'd1);
    chk({tag, "_busy_at_rdy"}, {31'h0, bar}, 32'd0);
    chk({tag, "_result"}, res, exp_r);
    chk({tag, "_exc"}, {31'h0, exc}, {31'h0, exp_e});
    chk({tag, "_rdy_single"}, {31'h0, rn}, 32'd0);
  endtask

  initial begin
    int          rdy_seen;
    logic [7:0]  ra, rb, mr;
    logic signed [7:0] sa, sb;
    int          ia, ib, ip, iq;
    bit          mm, me;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_result32", r32, 32'h0);
    chk("rst_exc32", {31'h0, e32}, 32'd0);
    chk("rst_rdy32", {31'h0, rdy32}, 32'd0);
    chk("rst_busy32", {31'h0, busy32}, 32'd0);
    chk("rst_busy8", {31'h0, busy8}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_rdy32", {31'h0, rdy32}, 32'd0);

    // Multiplies, WIDTH=32
    check_op("mul_7x-6",      1'b0, 1'b1, 1'b0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0);
    check_op("mul_maxx2",     1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1);
    check_op("mul_minx1",     1'b0, 1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0);

    // Divides, WIDTH=32
    check_op("div_-7/2",      1'b0, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    check_op("div_100/0",     1'b0, 1'b0, 1'b1, 32'd100,      32'd0,        32'h0,        1'b1);
    check_op("div_min/-1",    1'b0, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    check_op("div_0/-3",      1'b0, 1'b0, 1'b1, 32'd0,        32'hFFFFFFFD, 32'h0,        1'b0);

    // Outputs hold while idle
    repeat (3) @(negedge clk);
    chk("hold_result", r32, 32'h0);
    chk("hold_exc", {31'h0, e32}, 32'd0);

    // Restart: multiply aborted by a divide 10 cycles later
    @(negedge clk);
    a32 = 32'd3; b32 = 32'd4; m32 = 1'b1;
    @(negedge clk);
    m32 = 1'b0;
    rdy_seen = 0;
    repeat (9) begin
      @(negedge clk);
      if (rdy32) rdy_seen++;
    end
    check_op("restart_div20/5", 1'b0, 1'b0, 1'b1, 32'd20, 32'd5, 32'd4, 1'b0);
    chk("restart_no_mul_rdy", 32'(rdy_seen), 32'd0);

    // Simultaneous start: multiply wins
    check_op("both_6x3", 1'b0, 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);

    // Reset in the middle of a divide
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; d32 = 1'b1;
    @(negedge clk);
    d32 = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_result", r32, 32'h0);
    chk("midrst_busy", {31'h0, busy32}, 32'd0);
    chk("midrst_rdy", {31'h0, rdy32}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rdy32) rdy_seen++;
    end
    chk("midrst_no_rdy", 32'(rdy_seen), 32'd0);
    check_op("post_rst_5x5", 1'b0, 1'b1, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0);

    // WIDTH=8 directed
    check_op("w8_mul_-8x16",  1'b1, 1'b1, 1'b0, 32'hF8, 32'h10, 32'h80, 1'b0);
    check_op("w8_mul_16x16",  1'b1, 1'b1, 1'b0, 32'h10, 32'h10, 32'h00, 1'b1);
    check_op("w8_div_min/-1", 1'b1, 1'b0, 1'b1, 32'h80, 32'hFF, 32'h80, 1'b1);
    check_op("w8_div_-100/7", 1'b1, 1'b0, 1'b1, 32'h9C, 32'h07, 32'hF2, 1'b0);
    check_op("w8_div_5/0",    1'b1, 1'b0, 1'b1, 32'h05, 32'h00, 32'h00, 1'b1);

    // WIDTH=8 random signed ops against an integer reference
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      mm = 1'($urandom);
      sa = ra; sb = rb;
      ia = sa; ib = sb;
      if (mm) begin
        ip = ia * ib;
        mr = ip[7:0];
        me = (ip > 127) || (ip < -128);
      end else if (ib == 0) begin
        mr = 8'h00; me = 1'b1;
      end else if (ia == -128 && ib == -1) begin
        mr = 8'h80; me = 1'b1;
      end else begin
        iq = ia / ib;
        mr = iq[7:0]; me = 1'b0;
      end
      check_op(mm ? "w8_rnd_mul" : "w8_rnd_div", 1'b1, mm, ~mm,
               {24'h0, ra}, {24'h0, rb}, {24'h0, mr}, me);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_iter.md
Name: multdiv_iter

Overview:
- Parametrised iterative signed multiply/divide unit for the pipelined core's execute stage.
- Accepts a one-cycle start pulse and computes over a fixed number of cycles.
- Returns a WIDTH-bit result, an exception flag and a one-cycle ready pulse.
- The DX stage stalls on busy and captures the result on data_resultRDY.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 4..64.

Ports:
clock  input  1  master clock, rising-edge.
reset  input  1  asynchronous, active-low; 0 clears all state immediately.
data_operandA  input  WIDTH  multiplicand / dividend, two's complement.
data_operandB  input  WIDTH  multiplier / divisor, two's complement.
ctrl_MULT  input  1  start-multiply pulse, sampled on a rising edge.
ctrl_DIV  input  1  start-divide pulse, sampled on a rising edge.
data_result  output  WIDTH  low WIDTH bits of the product, or the quotient; registered.
data_exception  output  1  overflow or divide-by-zero flag; registered.
data_resultRDY  output  1  one-cycle pulse when the result is valid.
busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0, state=IDLE, counter=0.
  - Reset during an operation aborts it; no RDY is produced for it.
- States:
  - IDLE: no operation.
  - MUL: multiply iterations.
  - DIV: divide iterations.
  - DONE: one cycle; writes data_result and data_exception, pulses data_resultRDY.
- Start:
  - Applies from any state.
  - The edge that samples ctrl_MULT=1 or ctrl_DIV=1 latches both operands and clears the counter.
  - State goes to MUL or DIV; busy=1 from that edge.
  - Operands are not re-read after the start edge.
- Simultaneous ctrl_MULT=1 and ctrl_DIV=1: multiply wins.
- Restart: a start while busy aborts the current operation silently; the new operation begins with full latency.
- Latency:
  - Fixed for both operations and independent of operand values.
  - data_resultRDY is high for exactly the one cycle following the (WIDTH+1)th rising edge after the start edge.
  - busy drops on that same edge.
- Outputs: data_result and data_exception update only on the DONE edge and hold until the next DONE or reset.
- Start in the RDY cycle: the current RDY pulse is unaffected; the new operation proceeds normally.
- Multiply:
  - Radix-2 shift-add (or Booth) on a 2*WIDTH-bit signed product, one bit per cycle, WIDTH iterations.
  - data_result = product[WIDTH-1:0].
  - data_exception=1 iff product[2*WIDTH-1:WIDTH-1] are not all equal, i.e. the product does not fit in WIDTH signed bits.
- Divide:
  - Restoring (or non-restoring) division on magnitudes, one quotient bit per cycle, WIDTH iterations.
  - Quotient sign = signA XOR signB; truncated toward zero; remainder discarded.
  - Divisor 0: data_result=0, data_exception=1, same latency.
  - MIN/-1 (MIN = 1 followed by WIDTH-1 zeros): data_result=MIN, data_exception=1.
  - Dividend 0: result 0, exception 0.
- Counter width: clog2(WIDTH)+1 bits; no wrap within an operation.
- IDLE with no start: all outputs hold and RDY stays 0.

Test Plan:
1. WIDTH=32, MULT with A=7, B=-6 -> RDY exactly 33 edges after start; result=0xFFFFFFD6 (-42); exc=0; busy high for 33 cycles.
2. WIDTH=32, MULT with A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exc=1. Then MULT with A=0x80000000, B=1 -> result=0x80000000, exc=0.
3. WIDTH=32 divides:
   - A=-7, B=2 -> result=0xFFFFFFFD (-3), exc=0.
   - A=100, B=0 -> result=0, exc=1, RDY after 33 edges.
   - A=0x80000000, B=-1 -> result=0x80000000, exc=1.
4. Restart: MULT 3*4, then DIV 20/5 issued 10 cycles later -> no RDY for the multiply; a single RDY 33 edges after the DIV start; result=4. Simultaneous MULT+DIV with A=6, B=3 -> result=18.
5. Reset: pull reset low at cycle 15 of a divide -> outputs zero immediately, no RDY. Release reset, then MULT 5*5 -> result=25 at normal latency.
6. WIDTH=8, MULT -8*16 -> result=0x80, exc=0; MULT 16*16 -> result=0x00, exc=1; RDY at 9 edges. Randomised signed ops checked against a reference model.
